// File: rtl/neuron_pkg.sv
// Shared types, config address map and reset defaults for the sequenced threshold network.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  localparam int OFF_W0   = 0;
  localparam int OFF_W1   = 1;
  localparam int OFF_BIAS = 2;
  localparam int OFF_THR  = 3;

  function automatic int out_base(input int nh);
    return 4 * nh;
  endfunction

  // Smallest accumulator that cannot overflow: two hidden products plus a bias.
  function automatic int acc_width(input int cw, input int xw);
    return $clog2(2 * ((1 << cw) - 1) * ((1 << xw) - 1) + (1 << cw));
  endfunction

  // Fixed network loaded at reset; anything past address 11 starts at zero.
  function automatic int cfg_default(input int addr);
    case (addr)
      0:       return 2;
      1:       return 1;
      2:       return 1;
      3:       return 6;
      4:       return 1;
      5:       return 3;
      6:       return 2;
      7:       return 10;
      8:       return 2;
      9:       return 2;
      10:      return 0;
      11:      return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Shared multiply-accumulate: acc_out = (clr ? bias : acc_in) + w*x, unsigned.
module neuron_mac #(
  parameter int CW   = 8,
  parameter int XW   = 4,
  parameter int ACCW = 14
) (
  input  logic            clr,
  input  logic [ACCW-1:0] acc_in,
  input  logic [CW-1:0]   bias,
  input  logic [CW-1:0]   w,
  input  logic [XW-1:0]   x,
  output logic [ACCW-1:0] acc_out
);

  logic [CW+XW-1:0] prod;

  assign prod    = w * x;
  assign acc_out = (clr ? ACCW'(bias) : acc_in) + ACCW'(prod);

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed two-layer threshold network: NUM_HID hidden neurons then one output
// neuron, all evaluated through a single MAC with a runtime-writable config file.
module neuron_layer_seq
  import neuron_pkg::*;
#(
  parameter int NUM_HID = 2,
  parameter int XW      = 4,
  parameter int CW      = 8,
  parameter int ACCW    = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*XW-1:0]     in_x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_y,
  output logic [NUM_HID-1:0]  out_hid,
  output logic                busy,
  input  logic                cfg_we,
  input  logic [7:0]          cfg_addr,
  input  logic [CW-1:0]       cfg_wdata,
  output logic                cfg_err
);

  localparam int NCFG = 5 * NUM_HID + 2;
  localparam int AW   = $clog2(NCFG);
  localparam int KW   = (NUM_HID > 1) ? $clog2(NUM_HID) : 1;
  localparam int OB   = out_base(NUM_HID);

  state_t state, state_nx;
  logic [KW-1:0]      k, j;
  logic               ph;
  logic [ACCW-1:0]    acc, mac_out;
  logic [2*XW-1:0]    xr;
  logic [NUM_HID-1:0] hid;
  logic [CW-1:0]      cfg [NCFG];
  logic [CW-1:0]      op_w, op_b, op_t;
  logic [XW-1:0]      op_x;
  logic               op_clr, gt, accept, cfg_ok, last_k, last_j;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign cfg_ok    = (state == IDLE) && (int'(cfg_addr) < NCFG);
  assign last_k    = (k == KW'(NUM_HID - 1));
  assign last_j    = (j == KW'(NUM_HID - 1));

  // Operand mux: hidden phase selects W0/x0 or W1/x1; output layer walks V_j over hid[j].
  always_comb begin
    op_w   = '0;
    op_b   = '0;
    op_t   = '0;
    op_x   = '0;
    op_clr = 1'b0;
    if (state == OUT) begin
      op_w   = cfg[AW'(OB + int'(j))];
      op_b   = cfg[AW'(OB + NUM_HID)];
      op_t   = cfg[AW'(OB + NUM_HID + 1)];
      op_x   = XW'(hid[j]);
      op_clr = (j == '0);
    end else begin
      op_w   = ph ? cfg[AW'(4 * int'(k) + OFF_W1)] : cfg[AW'(4 * int'(k) + OFF_W0)];
      op_b   = cfg[AW'(4 * int'(k) + OFF_BIAS)];
      op_t   = cfg[AW'(4 * int'(k) + OFF_THR)];
      op_x   = ph ? xr[2*XW-1:XW] : xr[XW-1:0];
      op_clr = !ph;
    end
  end

  neuron_mac #(.CW(CW), .XW(XW), .ACCW(ACCW)) u_mac (
    .clr     (op_clr),
    .acc_in  (acc),
    .bias    (op_b),
    .w       (op_w),
    .x       (op_x),
    .acc_out (mac_out)
  );

  assign gt = (mac_out > ACCW'(op_t));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = HID;
      HID:     if (ph && last_k) state_nx = OUT;
      OUT:     if (last_j) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= '0;
      j       <= '0;
      ph      <= 1'b0;
      acc     <= '0;
      xr      <= '0;
      hid     <= '0;
      out_y   <= 1'b0;
      out_hid <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NCFG; i++) cfg[AW'(i)] <= CW'(cfg_default(i));
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) cfg[AW'(cfg_addr)] <= cfg_wdata;
      case (state)
        IDLE: if (accept) begin
          xr      <= in_x;
          out_hid <= '0;
          hid     <= '0;
          k       <= '0;
          ph      <= 1'b0;
        end
        HID: begin
          ph <= !ph;
          if (!ph) acc <= mac_out;
          else begin
            hid[k] <= gt;
            if (last_k) j <= '0;
            else        k <= k + KW'(1);
          end
        end
        OUT: begin
          acc <= mac_out;
          if (last_j) begin
            out_y   <= gt;
            out_hid <= hid;
          end else j <= j + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
